// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared constants and state encoding for the framebuffer
//                write path (write arbiter, sweep counter, scan-out).
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

    // Visible raster and bus widths
    localparam int H_RES       = 320;
    localparam int V_RES       = 240;
    localparam int COORD_W     = 11;
    localparam int COLOR_W     = 3;

    // Colour written by the full-screen clear sweep
    localparam int CLEAR_COLOR = 0;

    // Arbiter state encoding. ST_DONE is a reserved code; any code other
    // than ST_CLEAR behaves exactly like ST_IDLE.
    typedef logic [1:0] fb_state_t;
    localparam fb_state_t ST_IDLE  = 2'b00;
    localparam fb_state_t ST_CLEAR = 2'b01;
    localparam fb_state_t ST_DONE  = 2'b10;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_sweep_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_sweep_counter
//  Description : Row-major raster counter. Load returns it to (0,0); enable
//                advances one pixel with x wrapping at H_RES-1 and y stepping
//                on that wrap. Exposes the raster successor of the current
//                position and a combinational last-pixel flag so a caller can
//                register the next coordinate without a second adder.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_sweep_counter
    import fb_pkg::*;
#(
    parameter int H_RES   = fb_pkg::H_RES,
    parameter int V_RES   = fb_pkg::V_RES,
    parameter int COORD_W = fb_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_en,
    output logic [COORD_W-1:0] o_next_x,
    output logic [COORD_W-1:0] o_next_y,
    output logic               o_last
);

    // Limits are the last legal coordinate, so a counter can never reach
    // H_RES or V_RES even for one cycle.
    localparam logic [COORD_W-1:0] c_x_max = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] c_y_max = COORD_W'(V_RES - 1);
    localparam logic [COORD_W-1:0] c_zero  = '0;
    localparam logic [COORD_W-1:0] c_one   = COORD_W'(1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic [COORD_W-1:0] w_next_x;
    logic [COORD_W-1:0] w_next_y;

    // Successor of the current position in row-major order
    always_comb begin
        w_x_wrap = (r_x == c_x_max);
        w_y_wrap = (r_y == c_y_max);
        w_next_x = w_x_wrap ? c_zero : (r_x + c_one);
        w_next_y = w_x_wrap ? (w_y_wrap ? c_zero : (r_y + c_one)) : r_y;
    end

    // Position register: load has priority over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= c_zero;
            r_y <= c_zero;
        end else if (i_load) begin
            r_x <= c_zero;
            r_y <= c_zero;
        end else if (i_en) begin
            r_x <= w_next_x;
            r_y <= w_next_y;
        end
    end

    assign o_next_x = w_next_x;
    assign o_next_y = w_next_y;
    assign o_last   = w_x_wrap && w_y_wrap;

endmodule : fb_sweep_counter
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_arbiter
//  Description : Sole owner of the framebuffer write port. A full-screen
//                clear sweep (one-cycle trigger) has priority over a
//                valid/ready pixel-draw stream; draws stall while the sweep
//                runs. All writes leave on one registered port.
//  Options     : FB_DRAW_CLIP_EN - when defined, accepted draws with
//                x >= H_RES or y >= V_RES are handshaken but not written.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int H_RES       = fb_pkg::H_RES,
    parameter int V_RES       = fb_pkg::V_RES,
    parameter int COORD_W     = fb_pkg::COORD_W,
    parameter int COLOR_W     = fb_pkg::COLOR_W,
    parameter int CLEAR_COLOR = fb_pkg::CLEAR_COLOR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               clear_done,
    input  logic               draw_valid,
    output logic               draw_ready,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COLOR_W-1:0] draw_color,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic [COLOR_W-1:0] fb_color,
    output logic               fb_we
);

    localparam logic [COLOR_W-1:0] c_clear_color = COLOR_W'(CLEAR_COLOR);
    localparam logic [COORD_W-1:0] c_zero        = '0;

    fb_state_t          r_state;
    fb_state_t          w_state_next;

    logic               w_sweep_active;
    logic               w_sweep_load;
    logic               w_sweep_en;
    logic               w_sweep_last;
    logic [COORD_W-1:0] w_sweep_next_x;
    logic [COORD_W-1:0] w_sweep_next_y;

    logic               w_draw_ready;
    logic               w_accept;
    logic               w_in_range;

    logic [COORD_W-1:0] r_fb_x;
    logic [COORD_W-1:0] r_fb_y;
    logic [COLOR_W-1:0] r_fb_color;
    logic               r_fb_we;
    logic               r_clear_done;

    // The counter tracks the coordinate currently on the fb port during a
    // sweep; its successor is what gets registered onto the port next.
    fb_sweep_counter #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COORD_W (COORD_W)
    ) u_sweep (
        .clk      (clock),
        .rst      (reset),
        .i_load   (w_sweep_load),
        .i_en     (w_sweep_en),
        .o_next_x (w_sweep_next_x),
        .o_next_y (w_sweep_next_y),
        .o_last   (w_sweep_last)
    );

`ifdef FB_DRAW_CLIP_EN
    // Off-screen draws still complete the handshake but are never written
    localparam logic [COORD_W-1:0] c_x_max = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] c_y_max = COORD_W'(V_RES - 1);
    assign w_in_range = (draw_x <= c_x_max) && (draw_y <= c_y_max);
`else
    // Caller guarantees on-screen coordinates
    assign w_in_range = 1'b1;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a clear request during a sweep is ignored, and every
    // code other than ST_CLEAR (including the reserved one) acts as idle
    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_CLEAR: w_state_next = w_sweep_last ? ST_IDLE : ST_CLEAR;
            default:  w_state_next = clear_req ? ST_CLEAR : ST_IDLE;
        endcase
    end

    // State-decoded controls: clear beats a simultaneous draw
    always_comb begin
        w_sweep_active = (r_state == ST_CLEAR);
        w_draw_ready   = !w_sweep_active && !clear_req;
        w_accept       = draw_valid && w_draw_ready;
        w_sweep_load   = !w_sweep_active && clear_req;
        w_sweep_en     = w_sweep_active && !w_sweep_last;
    end

    // Registered write port and completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fb_x       <= c_zero;
            r_fb_y       <= c_zero;
            r_fb_color   <= '0;
            r_fb_we      <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_fb_we      <= 1'b0;
            r_clear_done <= 1'b0;
            if (w_sweep_active) begin
                if (w_sweep_last) begin
                    r_clear_done <= 1'b1;
                end else begin
                    r_fb_we    <= 1'b1;
                    r_fb_x     <= w_sweep_next_x;
                    r_fb_y     <= w_sweep_next_y;
                    r_fb_color <= c_clear_color;
                end
            end else if (clear_req) begin
                // First sweep pixel goes out the cycle after the request
                r_fb_we    <= 1'b1;
                r_fb_x     <= c_zero;
                r_fb_y     <= c_zero;
                r_fb_color <= c_clear_color;
            end else if (w_accept && w_in_range) begin
                r_fb_we    <= 1'b1;
                r_fb_x     <= draw_x;
                r_fb_y     <= draw_y;
                r_fb_color <= draw_color;
            end
        end
    end

    assign clear_busy = w_sweep_active;
    assign clear_done = r_clear_done;
    assign draw_ready = w_draw_ready;
    assign fb_x       = r_fb_x;
    assign fb_y       = r_fb_y;
    assign fb_color   = r_fb_color;
    assign fb_we      = r_fb_we;

endmodule : fb_write_arbiter
`default_nettype wire
